// File: rtl/cpu15_core.sv
// -----------------------------------------------------------------------------
// cpu15_core: single-clock 15-bit-instruction CPU.
// An internal phase sequencer steps FT -> DC -> EX -> WB for each instruction.
// The register file (8 x 16), data RAM and memory-mapped I/O registers are
// internal. Instruction memory is external.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET_N    synchronous active-low reset
//   IMEM_ADDR  instruction address, always the current PC
//   IMEM_DATA  15-bit instruction word
//   IMEM_VALID IMEM_DATA is valid for IMEM_ADDR
//   IO_IN      IO_PORTS x 16-bit input ports, port k at [16k+15:16k]
//   IO_OUT     IO_PORTS x 16-bit registered output ports
//   PHASE      current phase (0 FT, 1 DC, 2 EX, 3 WB); 0 while halted
//   HALTED     high while in HALT
//
// Fetch handshake: the core presents IMEM_ADDR and waits in FT. IMEM_DATA is
// taken on the first rising edge in FT where IMEM_VALID=1; until then nothing
// in the core changes. There is no ready signal: the core is always ready in
// FT and ignores IMEM_VALID in every other phase.
// -----------------------------------------------------------------------------
module cpu15_core #(
  parameter int PC_W      = 8,
  parameter int RAM_DEPTH = 8,
  parameter int IO_BASE   = 64,
  parameter int IO_PORTS  = 1
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  output logic [PC_W-1:0]        IMEM_ADDR,
  input  logic [14:0]            IMEM_DATA,
  input  logic                   IMEM_VALID,
  input  logic [16*IO_PORTS-1:0] IO_IN,
  output logic [16*IO_PORTS-1:0] IO_OUT,
  output logic [1:0]             PHASE,
  output logic                   HALTED
);

  localparam logic [1:0] PH_FT = 2'd0;
  localparam logic [1:0] PH_DC = 2'd1;
  localparam logic [1:0] PH_EX = 2'd2;
  localparam logic [1:0] PH_WB = 2'd3;

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_SL  = 4'd5;
  localparam logic [3:0] OP_SR  = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_LDL = 4'd8;
  localparam logic [3:0] OP_LDH = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_JE  = 4'd11;
  localparam logic [3:0] OP_JMP = 4'd12;
  localparam logic [3:0] OP_LD  = 4'd13;
  localparam logic [3:0] OP_ST  = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  logic [PC_W-1:0] pc_q, pc_d, npc_q, npc_d;
  logic [14:0]     ir_q, ir_d;
  logic [1:0]      phase_q, phase_d;
  logic            halted_q, halted_d;
  logic            eq_q, eq_d;
  logic [15:0]     opa_q, opa_d, opb_q, opb_d, mem_q, mem_d, res_q, res_d;
  logic [15:0]     regs_q [8];
  logic [15:0]     regs_d [8];
  logic [15:0]     ram_q  [RAM_DEPTH];
  logic [15:0]     ram_d  [RAM_DEPTH];
  logic [15:0]     io_q   [IO_PORTS];
  logic [15:0]     io_d   [IO_PORTS];

  logic [3:0] op;
  logic [2:0] ra, rb;
  logic [7:0] imm;

  assign op  = ir_q[14:11];
  assign ra  = ir_q[10:8];
  assign rb  = ir_q[7:5];
  assign imm = ir_q[7:0];

  always_comb begin
    pc_d     = pc_q;
    npc_d    = npc_q;
    ir_d     = ir_q;
    phase_d  = phase_q;
    halted_d = halted_q;
    eq_d     = eq_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    mem_d    = mem_q;
    res_d    = res_q;
    regs_d   = regs_q;
    ram_d    = ram_q;
    io_d     = io_q;

    // HALT freezes everything; only reset leaves it.
    if (!halted_q) begin
      unique case (phase_q)
        PH_FT: begin
          if (IMEM_VALID) begin
            ir_d    = IMEM_DATA;
            phase_d = PH_DC;
          end
        end
        PH_DC: begin
          opa_d = regs_q[ra];
          opb_d = regs_q[rb];
          // Addresses outside RAM and the I/O window read as zero.
          mem_d = 16'd0;
          for (int i = 0; i < RAM_DEPTH; i++)
            if (int'(imm) == i) mem_d = ram_q[i];
          for (int k = 0; k < IO_PORTS; k++)
            if (int'(imm) == IO_BASE + k) mem_d = IO_IN[16*k +: 16];
          phase_d = PH_EX;
        end
        PH_EX: begin
          npc_d = pc_q + PC_W'(1);
          res_d = opa_q;
          case (op)
            OP_MOV: res_d = opb_q;
            OP_ADD: res_d = opa_q + opb_q;
            OP_SUB: res_d = opa_q - opb_q;
            OP_AND: res_d = opa_q & opb_q;
            OP_OR:  res_d = opa_q | opb_q;
            OP_SL:  res_d = {opa_q[14:0], 1'b0};
            OP_SR:  res_d = {1'b0, opa_q[15:1]};
            OP_SRA: res_d = {opa_q[15], opa_q[15:1]};
            OP_LDL: res_d = {opa_q[15:8], imm};
            OP_LDH: res_d = {imm, opa_q[7:0]};
            OP_LD:  res_d = mem_q;
            OP_JE:  if (eq_q) npc_d = imm[PC_W-1:0];
            OP_JMP: npc_d = imm[PC_W-1:0];
            default: ;
          endcase
          // hlt never reaches WB, so the PC stays on the hlt address.
          if (op == OP_HLT) begin
            halted_d = 1'b1;
            phase_d  = PH_FT;
          end else begin
            phase_d = PH_WB;
          end
        end
        PH_WB: begin
          if (op <= OP_LDH || op == OP_LD) regs_d[ra] = res_q;
          if (op == OP_CMP) eq_d = (opa_q == opb_q);
          if (op == OP_ST) begin
            // Stores outside RAM and the I/O window are dropped.
            for (int i = 0; i < RAM_DEPTH; i++)
              if (int'(imm) == i) ram_d[i] = opa_q;
            for (int k = 0; k < IO_PORTS; k++)
              if (int'(imm) == IO_BASE + k) io_d[k] = opa_q;
          end
          pc_d    = npc_q;
          phase_d = PH_FT;
        end
        default: phase_d = PH_FT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pc_q     <= '0;
      npc_q    <= '0;
      ir_q     <= '0;
      phase_q  <= PH_FT;
      halted_q <= 1'b0;
      eq_q     <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      mem_q    <= '0;
      res_q    <= '0;
      for (int i = 0; i < 8; i++)         regs_q[i] <= '0;
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i]  <= '0;
      for (int k = 0; k < IO_PORTS; k++)  io_q[k]   <= '0;
    end else begin
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      ir_q     <= ir_d;
      phase_q  <= phase_d;
      halted_q <= halted_d;
      eq_q     <= eq_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mem_q    <= mem_d;
      res_q    <= res_d;
      regs_q   <= regs_d;
      ram_q    <= ram_d;
      io_q     <= io_d;
    end
  end

  assign IMEM_ADDR = pc_q;
  assign PHASE     = phase_q;
  assign HALTED    = halted_q;

  for (genvar k = 0; k < IO_PORTS; k++) begin : g_io_out
    assign IO_OUT[16*k +: 16] = io_q[k];
  end

endmodule
